music_note_decoder: RTL and testbench

- Receive-side counterpart of the melody PWM/square-wave player.
- Samples a 1-bit audio tone line and measures the period between rising edges.
- Classifies each period into the player's note IDs (C4..G5, REST) and reports each completed note with its duration.
- Used as an on-chip loopback checker and as a standalone tune recogniser.

---
 rtl/music_note_decoder.sv | 226 ++++++++++++++++++++++
 tb/tb_music_note_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/music_note_decoder.sv
// Tone-line note decoder: measures rising-edge periods on audio_in, classifies them
// against the melody player's note table and reports each finished note with its length.
module music_note_decoder #(
    parameter int CLK_FREQ       = 25000000,
    parameter int TICK_HZ        = 1000,
    parameter int CONFIRM        = 3,
    parameter int TIMEOUT_CYCLES = 131071
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        audio_in,
    output logic [3:0]  note_id,
    output logic        event_valid,
    output logic [3:0]  event_note,
    output logic [11:0] event_len
);

    localparam int          PRESCALE  = CLK_FREQ / TICK_HZ;
    localparam int          PW        = (PRESCALE > 32'sd1) ? $clog2(PRESCALE) : 32'sd1;
    localparam int          NUM_NOTES = 32'sd12;
    localparam logic [3:0]  REST      = 4'd15;
    localparam logic [16:0] TIMEOUT   = 17'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {WAIT_EDGE = 1'b0, MEASURE = 1'b1} state_t;

    // The table is defined at 25 MHz; other clock rates scale it proportionally.
    function automatic logic [16:0] note_period(input logic [3:0] idx);
        logic [63:0] base;
        case (idx)
            4'd0:    base = 64'd95555;
            4'd1:    base = 64'd85132;
            4'd2:    base = 64'd75843;
            4'd3:    base = 64'd71586;
            4'd4:    base = 64'd63776;
            4'd5:    base = 64'd56818;
            4'd6:    base = 64'd50619;
            4'd7:    base = 64'd47778;
            4'd8:    base = 64'd42566;
            4'd9:    base = 64'd37921;
            4'd10:   base = 64'd35793;
            4'd11:   base = 64'd31888;
            default: base = 64'd0;
        endcase
        return 17'((base * 64'(CLK_FREQ)) / 64'd25000000);
    endfunction

    function automatic logic [16:0] win_lo(input logic [3:0] idx);
        logic [16:0] t;
        t = note_period(idx);
        return t - {6'd0, t[16:6]};
    endfunction

    function automatic logic [16:0] win_hi(input logic [3:0] idx);
        logic [16:0] t;
        t = note_period(idx);
        return t + {6'd0, t[16:6]};
    endfunction

    logic          sync1_r, sync2_r, sync3_r;
    logic          edge_s;
    state_t        state_r, state_n_s;
    logic [16:0]   per_cnt_r;
    logic          cnt_clear_s, classify_s, timeout_s;
    logic [11:0]   hit_s;
    logic          match_ok_s;
    logic [3:0]    match_s;
    logic [3:0]    cand_r, cand_n_s;
    logic [2:0]    conf_r, conf_n_s;
    logic          chg_req_s, chg_r;
    logic [3:0]    chg_note_s, chg_note_r;
    logic [PW-1:0] presc_r;
    logic [11:0]   dur_r;

    // Two-flop synchroniser plus one delay stage for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= audio_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign edge_s = sync2_r & ~sync3_r;

    // State register and period counter; counter holds p at the next strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= WAIT_EDGE;
            per_cnt_r <= 17'd0;
        end else begin
            state_r <= state_n_s;
            if (cnt_clear_s) begin
                per_cnt_r <= 17'd1;
            end else if (per_cnt_r != 17'h1FFFF) begin
                per_cnt_r <= per_cnt_r + 17'd1;
            end else begin
                per_cnt_r <= per_cnt_r;
            end
        end
    end

    // Next state and measurement strobes; an edge beats a simultaneous timeout
    always_comb begin
        state_n_s   = state_r;
        cnt_clear_s = 1'b0;
        classify_s  = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            WAIT_EDGE: begin
                if (edge_s) begin
                    state_n_s   = MEASURE;
                    cnt_clear_s = 1'b1;
                end else begin
                    state_n_s = WAIT_EDGE;
                end
            end
            MEASURE: begin
                if (edge_s) begin
                    classify_s  = 1'b1;
                    cnt_clear_s = 1'b1;
                end else if (per_cnt_r == TIMEOUT) begin
                    timeout_s = 1'b1;
                    state_n_s = WAIT_EDGE;
                end else begin
                    state_n_s = MEASURE;
                end
            end
            default: state_n_s = WAIT_EDGE;
        endcase
    end

    // Window compare of the measured period against every note
    always_comb begin
        hit_s   = 12'd0;
        match_s = REST;
        for (int i = 32'sd0; i < NUM_NOTES; i++) begin
            hit_s[i] = (per_cnt_r >= win_lo(4'(i))) && (per_cnt_r <= win_hi(4'(i)));
            match_s  = hit_s[i] ? 4'(i) : match_s;
        end
        match_ok_s = |hit_s;
    end

    // Confirmation: a new note must repeat CONFIRM times; timeout forces REST at once
    always_comb begin
        cand_n_s   = cand_r;
        conf_n_s   = conf_r;
        chg_req_s  = 1'b0;
        chg_note_s = note_id;
        if (timeout_s) begin
            conf_n_s   = 3'd0;
            chg_req_s  = (note_id != REST);
            chg_note_s = REST;
        end else if (classify_s) begin
            if (!match_ok_s || (match_s == note_id)) begin
                conf_n_s = 3'd0;
            end else begin
                if (match_s == cand_r) begin
                    conf_n_s = conf_r + 3'd1;
                end else begin
                    cand_n_s = match_s;
                    conf_n_s = 3'd1;
                end
                if (conf_n_s == 3'(CONFIRM)) begin
                    chg_req_s  = 1'b1;
                    chg_note_s = match_s;
                    conf_n_s   = 3'd0;
                end else begin
                    chg_req_s = 1'b0;
                end
            end
        end else begin
            chg_req_s = 1'b0;
        end
    end

    // Candidate tracking and the one-cycle change request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_r     <= REST;
            conf_r     <= 3'd0;
            chg_r      <= 1'b0;
            chg_note_r <= REST;
        end else begin
            cand_r     <= cand_n_s;
            conf_r     <= conf_n_s;
            chg_r      <= chg_req_s;
            chg_note_r <= chg_note_s;
        end
    end

    // Duration ticks and registered note/event outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_id     <= REST;
            event_valid <= 1'b0;
            event_note  <= REST;
            event_len   <= 12'd0;
            dur_r       <= 12'd0;
            presc_r     <= '0;
        end else if (chg_r) begin
            note_id     <= chg_note_r;
            event_valid <= 1'b1;
            event_note  <= note_id;
            event_len   <= dur_r;
            dur_r       <= 12'd0;
            presc_r     <= '0;
        end else begin
            event_valid <= 1'b0;
            if (presc_r == PW'(PRESCALE - 32'sd1)) begin
                presc_r <= '0;
                if (dur_r != 12'hFFF) begin
                    dur_r <= dur_r + 12'd1;
                end else begin
                    dur_r <= dur_r;
                end
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_music_note_decoder.sv
// Self-checking bench for music_note_decoder, run at a scaled clock so whole tunes fit in a short run.
module tb_music_note_decoder;

    localparam int CLK_FREQ = 250000;
    localparam int TICK_HZ  = 125000;
    localparam int CONFIRM  = 3;
    localparam int TIMEOUT  = 1311;
    localparam int DIV      = CLK_FREQ / TICK_HZ;
    localparam int BASE [12] = '{95555, 85132, 75843, 71586, 63776, 56818,
                                 50619, 47778, 42566, 37921, 35793, 31888};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        audio_in = 1'b0;
    logic [3:0]  note_id, event_note;
    logic        event_valid;
    logic [11:0] event_len;

    int checks = 0, failures = 0, cyc = 0, ev_count = 0, last_rise = 0;

    // Reference model state: note-level view of the decoder
    bit m_armed = 1'b0, m_exp = 1'b0;
    int m_note = 15, m_cand = 15, m_cnt = 0, m_last = 0, m_ref = 0, m_ev_note = 15, m_ev_len = 0;

    music_note_decoder #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .CONFIRM(CONFIRM),
                         .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .audio_in(audio_in), .note_id(note_id),
        .event_valid(event_valid), .event_note(event_note), .event_len(event_len));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (event_valid === 1'b1) ev_count <= ev_count + 1;

    function automatic int t_of(input int i);
        longint b;
        b = BASE[i];
        return int'(b * CLK_FREQ / 25000000);
    endfunction

    function automatic int w_lo(input int i); return t_of(i) - (t_of(i) >> 6); endfunction
    function automatic int w_hi(input int i); return t_of(i) + (t_of(i) >> 6); endfunction

    function automatic int classify(input int p);
        int r;
        r = -1;
        for (int i = 0; i < 12; i++) if (p >= w_lo(i) && p <= w_hi(i)) r = i;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (!$isunknown(obs) && (int'(obs) + 1 >= exp) && (int'(obs) <= exp + 1)) else begin
            failures++;
            $error("FAIL %s: observed %0d, expected %0d (+/-1)", tag, obs, exp);
        end
    endtask

    task automatic m_reset(input int r);
        m_armed = 1'b0; m_note = 15; m_cand = 15; m_cnt = 0; m_exp = 1'b0; m_ref = r + 1;
    endtask

    // A change decided by an edge rising at cycle c; duration is whole ticks since the last change
    task automatic m_change(input int id, input int c);
        int t;
        t = (c + 4 - m_ref) / DIV;
        m_exp = 1'b1; m_ev_note = m_note; m_ev_len = (t > 4095) ? 4095 : t;
        m_note = id; m_ref = c + 5; m_cnt = 0;
    endtask

    task automatic m_edge(input int c);
        int id;
        if (!m_armed) begin
            m_armed = 1'b1;
        end else begin
            id = classify(c - m_last);
            if (id < 0 || id == m_note) m_cnt = 0;
            else begin
                if (id == m_cand) m_cnt++;
                else begin m_cand = id; m_cnt = 1; end
                if (m_cnt >= CONFIRM) m_change(id, c);
            end
        end
        m_last = c;
    endtask

    task automatic check_event(input string tag, input int ev0);
        chk({tag, "_note_id"}, note_id, m_note);
        chk({tag, "_events"}, ev_count - ev0, m_exp ? 1 : 0);
        if (m_exp) begin
            chk({tag, "_event_note"}, event_note, m_ev_note);
            chk_near({tag, "_event_len"}, event_len, m_ev_len);
        end
        m_exp = 1'b0;
    endtask

    task automatic edge_step(input int p);
        int ev0;
        audio_in = 1'b1; last_rise = cyc; ev0 = ev_count;
        m_edge(cyc);
        repeat (10) @(negedge clk);
        check_event("edge", ev0);
        repeat (p / 2 - 10) @(negedge clk);
        audio_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic tone(input int per, input int n, input int jit);
        int p;
        for (int k = 0; k < n; k++) begin
            p = per + int'($urandom_range(0, 2 * jit)) - jit;
            edge_step(p);
        end
    endtask

    task automatic silence();
        int ev0;
        ev0 = ev_count;
        repeat (last_rise + TIMEOUT - 3 - cyc) @(negedge clk);
        chk("pre_timeout_note", note_id, m_note);
        chk("pre_timeout_events", ev_count - ev0, 0);
        repeat (13) @(negedge clk);
        m_armed = 1'b0; m_cnt = 0;
        if (m_note != 15) m_change(15, last_rise + TIMEOUT);
        check_event("timeout", ev0);
    endtask

    task automatic do_reset(input int n, input bit toggle);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (toggle) audio_in = ~audio_in;
            @(negedge clk);
            chk("rst_note_id", note_id, 4'd15);
            chk("rst_event_valid", event_valid, 1'b0);
            chk("rst_event_note", event_note, 4'd15);
            chk("rst_event_len", event_len, 12'd0);
        end
        audio_in = 1'b0;
        rst = 1'b0;
        m_reset(cyc);
    endtask

    initial begin
        int ev0, kind, n;
        do_reset(5, 1'b1);
        repeat (3) @(negedge clk);
        chk("idle_note_id", note_id, 4'd15);
        chk("idle_event_valid", event_valid, 1'b0);
        chk("idle_event_len", event_len, 12'd0);
        chk("idle_events", ev_count, 0);

        // Steady A4, then a change to C5, then silence
        tone(t_of(5), 4, 0);
        chk("a4_note", note_id, 4'd5);
        chk("a4_from_rest", event_note, 4'd15);
        tone(t_of(5), 2, 0);
        tone(t_of(7), 4, 0);
        chk("c5_note", note_id, 4'd7);
        chk("c5_from_a4", event_note, 4'd5);
        silence();
        chk("silence_note", note_id, 4'd15);
        chk("silence_from_c5", event_note, 4'd7);

        // G4 window edges: inclusive bounds match, one cycle outside does not
        tone(w_hi(4), 4, 0);
        chk("g4_upper_edge", note_id, 4'd4);
        tone(w_hi(4) + 1, 4, 0);
        tone(600, 2, 0);
        chk("g4_outside_hold", note_id, 4'd4);
        tone(t_of(5), 4, 0);
        tone(w_lo(4), 4, 0);
        chk("g4_lower_edge", note_id, 4'd4);
        tone(t_of(5), 4, 0);
        tone(w_lo(4) - 1, 4, 0);
        chk("g4_below_hold", note_id, 4'd5);

        // A glitch restarts confirmation
        tone(t_of(7), 4, 0);
        ev0 = ev_count;
        edge_step(t_of(5)); edge_step(t_of(5)); edge_step(600);
        edge_step(t_of(5)); edge_step(t_of(5)); edge_step(t_of(7));
        chk("glitch_note", note_id, 4'd7);
        chk("glitch_events", ev_count - ev0, 0);

        // Long note saturates the duration
        tone(t_of(7), 20, 0);
        tone(t_of(5), 4, 0);
        chk("sat_note", note_id, 4'd5);
        chk("sat_event_len", event_len, 12'd4095);

        // Random tune: jittered notes, off-table periods and gaps
        for (int s = 0; s < 12; s++) begin
            kind = int'($urandom_range(0, 5));
            if (kind == 0 && m_armed) silence();
            else if (kind == 1) tone(int'($urandom_range(320, 960)), int'($urandom_range(1, 3)), 0);
            else begin
                n = int'($urandom_range(0, 11));
                tone(t_of(n), int'($urandom_range(2, 5)), t_of(n) >> 6);
            end
        end

        // Reset in the middle of a measurement
        tone(t_of(2), 2, 0);
        ev0 = ev_count;
        do_reset(3, 1'b0);
        repeat (2) @(negedge clk);
        chk("midrst_events", ev_count - ev0, 0);
        tone(t_of(2), 4, 0);
        chk("midrst_e4_note", note_id, 4'd2);
        chk("midrst_from_rest", event_note, 4'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
